snes_clk_seq: RTL and testbench



---
 rtl/snes_clk_pkg.sv | 28 ++
 rtl/frac_ce_gen.sv | 46 ++++
 rtl/snes_clk_seq.sv | 143 ++++++++++++++
 tb/tb_snes_clk_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_clk_pkg.sv
// Shared types and constants for the SNES clock/reset sequencer.
// Holds the sequencer state encoding, default master-clock ratio and CPU cycle-length table.
package snes_clk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DELAY    = 2'd2,
        ST_RUN      = 2'd3
    } clk_state_t;

    localparam int unsigned DEF_CE_NUM     = 32'd5369318;
    localparam int unsigned DEF_CE_DEN     = 32'd21600000;
    localparam logic [3:0]  CPU_PERIOD_RST = 4'd6;

    // CPU cycle length in master clocks for each cpu_speed code
    function automatic logic [3:0] cpu_period(input logic [1:0] speed);
        logic [3:0] period_s;
        case (speed)
            2'd0:    period_s = 4'd6;
            2'd1:    period_s = 4'd8;
            2'd2:    period_s = 4'd12;
            default: period_s = 4'd8;
        endcase
        return period_s;
    endfunction

endpackage

// File: rtl/frac_ce_gen.sv
// Exact rational clock-enable generator: CE_NUM pulses per CE_DEN enabled cycles.
// ce_next exposes the pulse decision one cycle early so callers can register aligned strobes.
module frac_ce_gen
    import snes_clk_pkg::*;
#(
    parameter int unsigned CE_NUM = DEF_CE_NUM,
    parameter int unsigned CE_DEN = DEF_CE_DEN,
    parameter int unsigned ACC_W  = $clog2(CE_DEN) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic ce,
    output logic ce_next
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;

    // acc stays below CE_DEN, so the sum fits in ACC_W bits without wrap
    assign sum_s   = acc_r + ACC_W'(CE_NUM);
    assign ce_next = en && (sum_s >= ACC_W'(CE_DEN));

    // Phase accumulator and registered enable pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            ce    <= 1'b0;
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
            ce    <= 1'b0;
        end else if (en) begin
            if (ce_next) begin
                acc_r <= sum_s - ACC_W'(CE_DEN);
                ce    <= 1'b1;
            end else begin
                acc_r <= sum_s;
                ce    <= 1'b0;
            end
        end else begin
            ce <= 1'b0;
        end
    end

endmodule

// File: rtl/snes_clk_seq.sv
// SNES power-up reset sequencer plus master-clock, dot and CPU-cycle enables.
// All strobes are single-cycle pulses in the fast clk domain.
module snes_clk_seq
    import snes_clk_pkg::*;
#(
    parameter int unsigned CE_NUM        = DEF_CE_NUM,
    parameter int unsigned CE_DEN        = DEF_CE_DEN,
    parameter int unsigned LOCK_STABLE   = 32'd65536,
    parameter int unsigned RELEASE_DELAY = 32'd1024,
    parameter int unsigned ACC_W         = $clog2(CE_DEN) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       mem_ready,
    input  logic       pause,
    input  logic [1:0] cpu_speed,
    output logic       mem_reset,
    output logic       snes_reset,
    output logic       mclk_ce,
    output logic       dot_ce,
    output logic       cpu_ce,
    output logic [1:0] state_o
);

    localparam int unsigned LOCK_W = $clog2(LOCK_STABLE) + 1;
    localparam int unsigned DLY_W  = $clog2(RELEASE_DELAY + 1) + 1;

    clk_state_t        state_r;
    clk_state_t        state_next_s;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [DLY_W-1:0]  dly_cnt_r;
    logic [1:0]        dot_cnt_r;
    logic [3:0]        cpu_cnt_r;
    logic [3:0]        period_r;
    logic              run_en_s;
    logic              clr_s;
    logic              tick_s;

    // Sequencer next-state decode; loss of lock dominates everything
    always_comb begin
        state_next_s = state_r;
        if (!pll_lock) begin
            state_next_s = ST_HOLD;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (lock_cnt_r == LOCK_W'(LOCK_STABLE - 1)) state_next_s = ST_WAIT_MEM;
                    else                                         state_next_s = ST_HOLD;
                end
                ST_WAIT_MEM: begin
                    if (mem_ready) state_next_s = ST_DELAY;
                    else           state_next_s = ST_WAIT_MEM;
                end
                ST_DELAY: begin
                    if (!mem_ready)                                  state_next_s = ST_WAIT_MEM;
                    else if (dly_cnt_r == DLY_W'(RELEASE_DELAY))     state_next_s = ST_RUN;
                    else                                             state_next_s = ST_DELAY;
                end
                ST_RUN: begin
                    if (!mem_ready) state_next_s = ST_WAIT_MEM;
                    else            state_next_s = ST_RUN;
                end
                default: state_next_s = ST_HOLD;
            endcase
        end
    end

    // Emulated time only advances on cycles that stay in RUN, so no pulse escapes on the exit edge
    assign run_en_s = (state_r == ST_RUN) && (state_next_s == ST_RUN) && !pause;
    assign clr_s    = (state_next_s != ST_RUN);
    assign state_o  = state_r;

    // State register and reset outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_HOLD;
            mem_reset  <= 1'b1;
            snes_reset <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            mem_reset  <= (state_next_s == ST_HOLD);
            snes_reset <= (state_next_s != ST_RUN);
        end
    end

    // Lock-stability and release-delay counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
            dly_cnt_r  <= {DLY_W{1'b0}};
        end else begin
            if ((state_r == ST_HOLD) && pll_lock) lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
            else                                  lock_cnt_r <= {LOCK_W{1'b0}};
            if ((state_r == ST_DELAY) && (state_next_s == ST_DELAY)) dly_cnt_r <= dly_cnt_r + DLY_W'(1);
            else                                                     dly_cnt_r <= {DLY_W{1'b0}};
        end
    end

    frac_ce_gen #(
        .CE_NUM (CE_NUM),
        .CE_DEN (CE_DEN),
        .ACC_W  (ACC_W)
    ) u_mclk_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .en      (run_en_s),
        .ce      (mclk_ce),
        .ce_next (tick_s)
    );

    // Dot and CPU dividers; the CPU period is only re-latched when a cycle completes
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_cnt_r <= 2'd0;
            cpu_cnt_r <= 4'd0;
            period_r  <= CPU_PERIOD_RST;
            dot_ce    <= 1'b0;
            cpu_ce    <= 1'b0;
        end else if (clr_s) begin
            dot_cnt_r <= 2'd0;
            cpu_cnt_r <= 4'd0;
            dot_ce    <= 1'b0;
            cpu_ce    <= 1'b0;
        end else if (tick_s) begin
            dot_cnt_r <= dot_cnt_r + 2'd1;
            dot_ce    <= (dot_cnt_r == 2'd3);
            if (cpu_cnt_r == (period_r - 4'd1)) begin
                cpu_cnt_r <= 4'd0;
                cpu_ce    <= 1'b1;
                period_r  <= cpu_period(cpu_speed);
            end else begin
                cpu_cnt_r <= cpu_cnt_r + 4'd1;
                cpu_ce    <= 1'b0;
            end
        end else begin
            dot_ce <= 1'b0;
            cpu_ce <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snes_clk_seq.sv
// Randomized bench for snes_clk_seq: three instances with different ratios run
// in lockstep against a floor(n*NUM/DEN) reference model, plus directed milestone checks.
module tb_snes_clk_seq;

    localparam int LS = 16;
    localparam int RD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       mem_ready;
    logic       pause;
    logic [1:0] cpu_speed;

    logic       mem_reset_v  [0:2];
    logic       snes_reset_v [0:2];
    logic       mclk_v       [0:2];
    logic       dot_v        [0:2];
    logic       cpu_v        [0:2];
    logic [1:0] st_v         [0:2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    snes_clk_seq #(.CE_NUM(3), .CE_DEN(8), .LOCK_STABLE(LS), .RELEASE_DELAY(RD)) dut_a (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .mem_ready(mem_ready), .pause(pause),
        .cpu_speed(cpu_speed), .mem_reset(mem_reset_v[0]), .snes_reset(snes_reset_v[0]),
        .mclk_ce(mclk_v[0]), .dot_ce(dot_v[0]), .cpu_ce(cpu_v[0]), .state_o(st_v[0]));

    snes_clk_seq #(.CE_NUM(5), .CE_DEN(5), .LOCK_STABLE(LS), .RELEASE_DELAY(RD)) dut_b (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .mem_ready(mem_ready), .pause(pause),
        .cpu_speed(cpu_speed), .mem_reset(mem_reset_v[1]), .snes_reset(snes_reset_v[1]),
        .mclk_ce(mclk_v[1]), .dot_ce(dot_v[1]), .cpu_ce(cpu_v[1]), .state_o(st_v[1]));

    snes_clk_seq #(.CE_NUM(5369), .CE_DEN(21600), .LOCK_STABLE(LS), .RELEASE_DELAY(RD)) dut_c (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .mem_ready(mem_ready), .pause(pause),
        .cpu_speed(cpu_speed), .mem_reset(mem_reset_v[2]), .snes_reset(snes_reset_v[2]),
        .mclk_ce(mclk_v[2]), .dot_ce(dot_v[2]), .cpu_ce(cpu_v[2]), .state_o(st_v[2]));

    // Reference model: sequencer milestones plus pulse count = floor(n*NUM/DEN)
    longint num_m [0:2] = '{64'd3, 64'd5, 64'd5369};
    longint den_m [0:2] = '{64'd8, 64'd5, 64'd21600};
    string  names [0:2] = '{"dut_a", "dut_b", "dut_c"};
    int     m_state, m_lock, m_dly;
    longint m_n [0:2];
    longint m_k [0:2];
    int     m_cpu [0:2];
    int     m_per [0:2];
    logic   e_mclk [0:2];
    logic   e_dot  [0:2];
    logic   e_cpu  [0:2];

    function automatic int period_of(input int s);
        case (s)
            0:       return 6;
            1:       return 8;
            2:       return 12;
            default: return 8;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        int ns;
        bit run;
        for (int i = 0; i < 3; i++) begin
            e_mclk[i] = 1'b0; e_dot[i] = 1'b0; e_cpu[i] = 1'b0;
        end
        if (rst) begin
            m_state = 0; m_lock = 0; m_dly = 0;
            for (int i = 0; i < 3; i++) begin
                m_n[i] = 0; m_k[i] = 0; m_cpu[i] = 0; m_per[i] = 6;
            end
            return;
        end
        ns = m_state;
        if (!pll_lock) begin
            ns = 0; m_lock = 0;
        end else begin
            case (m_state)
                0: begin m_lock++; if (m_lock == LS) begin ns = 1; m_lock = 0; end end
                1: if (mem_ready) begin ns = 2; m_dly = 0; end
                2: if (!mem_ready) ns = 1; else begin m_dly++; if (m_dly == RD + 1) ns = 3; end
                default: if (!mem_ready) ns = 1;
            endcase
        end
        run = (m_state == 3) && (ns == 3) && !pause;
        for (int i = 0; i < 3; i++) begin
            if (run) begin
                m_n[i]++;
                if ((m_n[i] * num_m[i]) / den_m[i] != ((m_n[i] - 1) * num_m[i]) / den_m[i]) begin
                    e_mclk[i] = 1'b1;
                    m_k[i]++;
                    e_dot[i] = (m_k[i] % 4 == 0);
                    m_cpu[i]++;
                    if (m_cpu[i] == m_per[i]) begin
                        e_cpu[i] = 1'b1;
                        m_cpu[i] = 0;
                        m_per[i] = period_of(int'(cpu_speed));
                    end
                end
            end else if (ns != 3) begin
                m_n[i] = 0; m_k[i] = 0; m_cpu[i] = 0;
            end
        end
        m_state = ns;
    endtask

    task automatic step();
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            exp_v = {2'(m_state), m_state == 0, m_state != 3, e_mclk[i], e_dot[i], e_cpu[i]};
            obs_v = {st_v[i], mem_reset_v[i], snes_reset_v[i], mclk_v[i], dot_v[i], cpu_v[i]};
            check_val(names[i], 64'(obs_v), 64'(exp_v));
        end
    endtask

    initial begin
        int mr_fall, sr_fall, prev_st, relock;
        int cnt_a, first_a, last_a, gap_bad, cnt_c, ncpu, last_dot, first_dot, dot_bad;
        int en_seen, rst_seen;
        int cpu_t [0:3];
        logic [7:0] walk;

        rst = 1'b1; pll_lock = 1'b0; mem_ready = 1'b0; pause = 1'b0; cpu_speed = 2'd2;
        repeat (3) step();
        check_val("rst_state", 64'(st_v[0]), 64'd0);
        check_val("rst_snes", 64'(snes_reset_v[0]), 64'd1);

        // Power-up sequencing: lock from cycle 1, mem_ready sampled at cycle 30
        rst = 1'b0; pll_lock = 1'b1;
        mr_fall = -1; sr_fall = -1; prev_st = 0; walk = 8'h00;
        for (int c = 1; c <= 60; c++) begin
            if (c == 30) mem_ready = 1'b1;
            step();
            if (mr_fall < 0 && mem_reset_v[0] == 1'b0) mr_fall = c;
            if (sr_fall < 0 && snes_reset_v[0] == 1'b0) sr_fall = c;
            if (int'(st_v[0]) != prev_st) begin
                walk = {walk[5:0], st_v[0]};
                prev_st = int'(st_v[0]);
            end
            if (sr_fall >= 0) break;
        end
        check_val("mem_reset_fall", 64'(mr_fall), 64'd16);
        check_val("snes_reset_fall", 64'(sr_fall), 64'd39);
        check_val("state_walk", 64'(walk), 64'h1B);

        // Rational rates and CPU period change mid-cycle
        cnt_a = 0; first_a = -1; last_a = -1; gap_bad = 0; cnt_c = 0;
        ncpu = 0; last_dot = -1; first_dot = -1; dot_bad = 0;
        for (int r = 1; r <= 21600; r++) begin
            if (r == 10) cpu_speed = 2'd0;
            step();
            if (r <= 800 && mclk_v[0]) begin
                cnt_a++;
                if (first_a < 0) first_a = r;
                if (last_a > 0 && (r - last_a < 2 || r - last_a > 3)) gap_bad++;
                last_a = r;
            end
            if (cpu_v[1] && ncpu < 4) begin
                cpu_t[ncpu] = r;
                ncpu++;
            end
            if (r <= 800 && dot_v[1]) begin
                if (first_dot < 0) first_dot = r;
                if (last_dot > 0 && r - last_dot != 4) dot_bad++;
                last_dot = r;
            end
            if (mclk_v[2]) cnt_c++;
        end
        check_val("a_first_pulse", 64'(first_a), 64'd3);
        check_val("a_pulse_count", 64'(cnt_a), 64'd300);
        check_val("a_gap", 64'(gap_bad), 64'd0);
        check_val("c_pulse_count", 64'(cnt_c), 64'd5369);
        check_val("cpu_ce0", 64'(ncpu > 0 ? cpu_t[0] : -1), 64'd6);
        check_val("cpu_ce1", 64'(ncpu > 1 ? cpu_t[1] : -1), 64'd18);
        check_val("cpu_ce2", 64'(ncpu > 2 ? cpu_t[2] : -1), 64'd24);
        check_val("cpu_ce3", 64'(ncpu > 3 ? cpu_t[3] : -1), 64'd30);
        check_val("dot_first", 64'(first_dot), 64'd4);
        check_val("dot_gap", 64'(dot_bad), 64'd0);

        // Pause: no strobes, resets untouched; phase continuity is checked by the lockstep model
        pause = 1'b1; en_seen = 0; rst_seen = 0;
        repeat (50) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (mclk_v[i] | dot_v[i] | cpu_v[i]) en_seen++;
                if (mem_reset_v[i] | snes_reset_v[i]) rst_seen++;
            end
        end
        pause = 1'b0;
        check_val("pause_enables", 64'(en_seen), 64'd0);
        check_val("pause_resets", 64'(rst_seen), 64'd0);
        repeat (200) step();

        // One-cycle lock glitch in RUN
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        check_val("glitch_state", 64'(st_v[0]), 64'd0);
        check_val("glitch_resets", 64'({mem_reset_v[0], snes_reset_v[0]}), 64'd3);
        check_val("glitch_en", 64'({mclk_v[1], dot_v[1], cpu_v[1]}), 64'd0);
        relock = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (mem_reset_v[0] == 1'b0) begin
                relock = c;
                break;
            end
        end
        check_val("relock_cycles", 64'(relock), 64'd16);
        repeat (30) step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            pause = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) cpu_speed = 2'($urandom_range(0, 3));
            pll_lock = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 299) == 0) mem_ready = 1'b0;
            else if ($urandom_range(0, 3) == 0) mem_ready = 1'b1;
            if (c == 2500) rst = 1'b1;
            step();
            if (c == 2500) begin
                rst = 1'b0;
                check_val("midrst_state", 64'(st_v[2]), 64'd0);
                check_val("midrst_en", 64'({mclk_v[1], dot_v[1], cpu_v[1]}), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
